// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the pmem responder and its backing store.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  localparam int PMEM_LINE_BYTES = 16;
  localparam int PMEM_LINES_LOG2 = 8;

  // Index type for the default store depth.
  typedef logic [PMEM_LINES_LOG2-1:0] lc3b_pmem_index;

  typedef enum logic [1:0] {
    PMEM_IDLE = 2'd0,
    PMEM_BUSY = 2'd1,
    PMEM_RESP = 2'd2
  } lc3b_pmem_state_t;

endpackage

// File: rtl/pmem_store.sv
// Line store behind pmem_responder: synchronous write, registered read that
// holds its value between read enables.
module pmem_store
  import lc3b_types::*;
#(
  parameter int LINES_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic [LINES_LOG2-1:0] index,
  input  logic [127:0]          datain,
  output logic [127:0]          dataout
);

  lc3b_line mem [2**LINES_LOG2];

  // NOTE: the array has no reset so it maps onto RAM macros; contents stay
  // undefined until written.
  always_ff @(posedge clk) begin
    if (we) mem[index] <= datain;
    if (re) dataout <= mem[index];
  end

endmodule

// File: rtl/pmem_responder.sv
// Line-granular pmem target with a programmable response delay.
// Define PMEM_PROTOCOL_CHECK_EN to enable the sticky protocol_err detector.
module pmem_responder
  import lc3b_types::*;
#(
  parameter int DELAY      = 4,
  parameter int LINES_LOG2 = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [15:0]  pmem_address,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         protocol_err
);

  localparam int         OFFSET_BITS = $clog2(PMEM_LINE_BYTES);
  localparam logic [3:0] CNT_LOAD    = 4'(DELAY - 1);

  lc3b_pmem_state_t      state;
  logic [3:0]            cnt;
  logic                  op_write;
  logic [LINES_LOG2-1:0] index_q;
  lc3b_line              wdata_q;
  lc3b_line              store_dout;
  logic                  rdata_valid;
  logic                  held;
  logic                  commit;
  logic                  store_we;
  logic                  store_re;
  logic                  unused_ok;

  // Abort is judged on the request line of the latched op only.
  assign held     = op_write ? pmem_write : pmem_read;
  assign commit   = (state == PMEM_BUSY) && held && (cnt == 4'd0);
  assign store_we = commit && op_write;
  assign store_re = commit && !op_write;

  assign pmem_resp  = (state == PMEM_RESP);
  assign pmem_rdata = rdata_valid ? store_dout : '0;
  assign unused_ok  = ^pmem_address;

  // Every request passes through BUSY, so RESP is entered DELAY edges after
  // sampling even when DELAY is 1.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PMEM_IDLE;
      cnt         <= 4'd0;
      op_write    <= 1'b0;
      index_q     <= '0;
      wdata_q     <= '0;
      rdata_valid <= 1'b0;
    end else begin
      if (store_re) rdata_valid <= 1'b1;
      case (state)
        PMEM_IDLE: begin
          if (pmem_read || pmem_write) begin
            op_write <= pmem_write;
            index_q  <= pmem_address[OFFSET_BITS +: LINES_LOG2];
            wdata_q  <= pmem_wdata;
            cnt      <= CNT_LOAD;
            state    <= PMEM_BUSY;
          end
        end
        PMEM_BUSY: begin
          if (!held)               state <= PMEM_IDLE;
          else if (cnt == 4'd0)    state <= PMEM_RESP;
          else                     cnt   <= cnt - 4'd1;
        end
        PMEM_RESP: state <= PMEM_IDLE;
        default:   state <= PMEM_IDLE;
      endcase
    end
  end

  pmem_store #(
    .LINES_LOG2(LINES_LOG2)
  ) u_store (
    .clk    (clk),
    .we     (store_we),
    .re     (store_re),
    .index  (index_q),
    .datain (wdata_q),
    .dataout(store_dout)
  );

`ifdef PMEM_PROTOCOL_CHECK_EN
  logic [15-OFFSET_BITS:0] line_q;
  logic                    err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == PMEM_IDLE) line_q <= pmem_address[15:OFFSET_BITS];
      if (state == PMEM_IDLE && pmem_read && pmem_write) err_q <= 1'b1;
      if (state == PMEM_BUSY &&
          (!held || pmem_address[15:OFFSET_BITS] != line_q)) err_q <= 1'b1;
    end
  end

  assign protocol_err = err_q;
`else
  assign protocol_err = 1'b0;
`endif

endmodule
